// File: rtl/uart_receiver_if.sv
// uart_receiver_if
//   Receive-side bus between uart_receiver and the host buffer/command logic.
//   data[7:0]      received word, right-justified, unused upper bits 0
//   valid          one-cycle strobe: data and error flags updated
//   parityError    parity mismatch in the last frame
//   frameError     a stop bit sampled low in the last frame
//   busy           high from start-bit detection to frame end
//   breakDetected  only when UART_RX_BREAK_DETECT_EN is defined
// Modports: master = receiver (drives), slave = consumer.
interface uart_receiver_if;
    logic [7:0] data;
    logic       valid;
    logic       parityError;
    logic       frameError;
    logic       busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       breakDetected;

    modport master (output data, valid, parityError, frameError, busy, breakDetected);
    modport slave  (input  data, valid, parityError, frameError, busy, breakDetected);
`else
    modport master (output data, valid, parityError, frameError, busy);
    modport slave  (input  data, valid, parityError, frameError, busy);
`endif
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver
//   Asynchronous serial receiver with run-time frame configuration
//   (5-8 data bits, optional parity with four modes, 1 or 2 stop bits,
//   24-bit clocks-per-bit divisor). Config is latched on start detection.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx              serial line, idle high, asynchronous to clk
//   dataBits        data bit count minus 5
//   hasParity       parity bit follows data
//   parityMode      00 space, 11 mark, 01 even, 10 odd
//   extraStopBit    two stop bits
//   clockDivisor    clk cycles per bit (values below 4 act as 4)
//   host            uart_receiver_if.master: data/valid/errors/busy
// Optional feature macro: UART_RX_BREAK_DETECT_EN (adds host.breakDetected
//   and a D-cycle high-line wait before re-arming after a break).
module uart_receiver #(
    parameter int unsigned SYNC_STAGES = 2  // minimum 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic [1:0]      dataBits,
    input  logic            hasParity,
    input  logic [1:0]      parityMode,
    input  logic            extraStopBit,
    input  logic [23:0]     clockDivisor,
    uart_receiver_if.master host
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} stateT;

    stateT                  state, stateNext;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                   rxs, rxsPrev;
    logic [23:0]            cnt, cntNext, div, divNext;
    logic [2:0]             bitIdx, bitIdxNext, lastBit, lastBitNext;
    logic                   parOn, parOnNext, twoStop, twoStopNext;
    logic [1:0]             parMode, parModeNext;
    logic [7:0]             shiftReg, shiftNext;
    logic                   parErr, parErrNext, frmErr, frmErrNext;
    logic [7:0]             dataReg, dataNext;
    logic                   parErrOut, parErrOutNext, frmErrOut, frmErrOutNext;
    logic                   sampleNow, halfNow, expParity;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                   parBit, parBitNext;
    logic                   brkFlag, brkFlagNext, brkWait, brkWaitNext, brkOut, brkOutNext;
`endif

    assign rxs = syncReg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            syncReg <= '1;
            rxsPrev <= 1'b1;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], rx};
            rxsPrev <= rxs;
        end
    end

    // shiftReg holds only received data bits (upper bits cleared), so a
    // full-width XOR is the data parity regardless of word length.
    always_comb begin
        case (parMode)
            2'b00:   expParity = 1'b0;
            2'b11:   expParity = 1'b1;
            2'b01:   expParity = ^shiftReg;
            default: expParity = ~^shiftReg;
        endcase
    end

    always_comb begin
        stateNext     = state;
        cntNext       = cnt + 24'd1;
        divNext       = div;
        bitIdxNext    = bitIdx;
        lastBitNext   = lastBit;
        parOnNext     = parOn;
        parModeNext   = parMode;
        twoStopNext   = twoStop;
        shiftNext     = shiftReg;
        parErrNext    = parErr;
        frmErrNext    = frmErr;
        dataNext      = dataReg;
        parErrOutNext = parErrOut;
        frmErrOutNext = frmErrOut;
`ifdef UART_RX_BREAK_DETECT_EN
        parBitNext    = parBit;
        brkFlagNext   = brkFlag;
        brkWaitNext   = brkWait;
        brkOutNext    = brkOut;
`endif
        sampleNow     = (cnt == div - 24'd1);
        halfNow       = (cnt == (div >> 1) - 24'd1);

        case (state)
            IDLE: begin
                cntNext = '0;
`ifdef UART_RX_BREAK_DETECT_EN
                // After a break, cnt counts consecutive high cycles; start
                // detection stays disarmed until D of them have been seen.
                if (brkWait) begin
                    if (rxs) begin
                        if (sampleNow) brkWaitNext = 1'b0;
                        else           cntNext     = cnt + 24'd1;
                    end
                end else
`endif
                if (rxsPrev && !rxs) begin
                    stateNext   = START;
                    divNext     = (clockDivisor < 24'd4) ? 24'd4 : clockDivisor;
                    lastBitNext = {1'b0, dataBits} + 3'd4;
                    parOnNext   = hasParity;
                    parModeNext = parityMode;
                    twoStopNext = extraStopBit;
                end
            end
            START: begin
                if (halfNow) begin
                    cntNext = '0;
                    if (rxs) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext  = DATA;
                        bitIdxNext = '0;
                        shiftNext  = '0;
                        parErrNext = 1'b0;
                        frmErrNext = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        parBitNext  = 1'b0;
                        brkFlagNext = 1'b0;
`endif
                    end
                end
            end
            DATA: begin
                if (sampleNow) begin
                    cntNext           = '0;
                    shiftNext[bitIdx] = rxs;
                    if (bitIdx == lastBit) stateNext  = parOn ? PARITY : STOP1;
                    else                   bitIdxNext = bitIdx + 3'd1;
                end
            end
            PARITY: begin
                if (sampleNow) begin
                    cntNext    = '0;
                    parErrNext = (rxs != expParity);
`ifdef UART_RX_BREAK_DETECT_EN
                    parBitNext = rxs;
`endif
                    stateNext  = STOP1;
                end
            end
            STOP1: begin
                if (sampleNow) begin
                    cntNext = '0;
                    if (!rxs) frmErrNext = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                    brkFlagNext = (shiftReg == '0) && !parBit && !rxs;
`endif
                    stateNext = twoStop ? STOP2 : DONE;
                end
            end
            STOP2: begin
                if (sampleNow) begin
                    cntNext = '0;
                    if (!rxs) frmErrNext = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                cntNext   = '0;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase

        // Outputs load on entry to DONE so they change together with valid.
        if (stateNext == DONE) begin
            dataNext      = shiftReg;
            parErrOutNext = parErrNext;
            frmErrOutNext = frmErrNext;
`ifdef UART_RX_BREAK_DETECT_EN
            brkOutNext    = brkFlagNext;
            brkWaitNext   = brkFlagNext;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            div       <= 24'd4;
            bitIdx    <= '0;
            lastBit   <= '0;
            parOn     <= 1'b0;
            parMode   <= '0;
            twoStop   <= 1'b0;
            shiftReg  <= '0;
            parErr    <= 1'b0;
            frmErr    <= 1'b0;
            dataReg   <= '0;
            parErrOut <= 1'b0;
            frmErrOut <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            parBit    <= 1'b0;
            brkFlag   <= 1'b0;
            brkWait   <= 1'b0;
            brkOut    <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            div       <= divNext;
            bitIdx    <= bitIdxNext;
            lastBit   <= lastBitNext;
            parOn     <= parOnNext;
            parMode   <= parModeNext;
            twoStop   <= twoStopNext;
            shiftReg  <= shiftNext;
            parErr    <= parErrNext;
            frmErr    <= frmErrNext;
            dataReg   <= dataNext;
            parErrOut <= parErrOutNext;
            frmErrOut <= frmErrOutNext;
`ifdef UART_RX_BREAK_DETECT_EN
            parBit    <= parBitNext;
            brkFlag   <= brkFlagNext;
            brkWait   <= brkWaitNext;
            brkOut    <= brkOutNext;
`endif
        end
    end

    assign host.data        = dataReg;
    assign host.valid       = (state == DONE);
    assign host.parityError = parErrOut;
    assign host.frameError  = frmErrOut;
    assign host.busy        = (state != IDLE) && (state != DONE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign host.breakDetected = brkOut;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Drives uart_receiver with a behavioural serial transmitter and compares
//   every valid strobe (cycle, data, flags) against frames predicted from
//   the frame rules. Build with or without UART_RX_BREAK_DETECT_EN.
module tb_uart_receiver;
    localparam int unsigned SYNC = 2;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        rx           = 1'b1;
    logic [1:0]  dataBits     = 2'd3;
    logic        hasParity    = 1'b0;
    logic [1:0]  parityMode   = 2'd0;
    logic        extraStopBit = 1'b0;
    logic [23:0] clockDivisor = 24'd10;

    uart_receiver_if bus ();

    uart_receiver #(.SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .dataBits     (dataBits),
        .hasParity    (hasParity),
        .parityMode   (parityMode),
        .extraStopBit (extraStopBit),
        .clockDivisor (clockDivisor),
        .host         (bus)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } recT;

    recT got[$];
    recT expQ[$];
    int  checks = 0;
    int  errors = 0;

    // Frame configuration as the model sees it
    int       cfgN    = 8;
    bit       cfgPar  = 1'b0;
    bit [1:0] cfgMode = 2'b00;
    bit       cfgTwo  = 1'b0;
    int       cfgDiv  = 10;

    always @(negedge clk) begin
        recT r;
        if (bus.valid === 1'b1) begin
            r.cyc = cycle;
            r.d   = bus.data;
            r.pe  = bus.parityError;
            r.fe  = bus.frameError;
`ifdef UART_RX_BREAK_DETECT_EN
            r.brk = bus.breakDetected;
`else
            r.brk = 1'b0;
`endif
            got.push_back(r);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int effD();
        return (cfgDiv < 4) ? 4 : cfgDiv;
    endfunction

    function automatic logic refParity(input logic [7:0] b, input int n, input bit [1:0] mode);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(b[i]);
        case (mode)
            2'b00:   return 1'b0;
            2'b11:   return 1'b1;
            2'b01:   return (ones % 2) == 1;
            default: return (ones % 2) == 0;
        endcase
    endfunction

    task automatic applyCfg();
        dataBits     = 2'(cfgN - 5);
        hasParity    = cfgPar;
        parityMode   = cfgMode;
        extraStopBit = cfgTwo;
        clockDivisor = 24'(cfgDiv);
    endtask

    task automatic driveBit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        driveBit(1'b1, n);
    endtask

    task automatic sendFrame(input logic [7:0] b, input int parForce, input logic s1,
                             input logic s2, input bit scramble,
                             output int k0, output logic sentPar);
        int d;
        d = effD();
        applyCfg();
        k0 = cycle;
        driveBit(1'b0, d);
        if (scramble) begin
            dataBits     = 2'($urandom);
            hasParity    = 1'($urandom);
            parityMode   = 2'($urandom);
            extraStopBit = 1'($urandom);
            clockDivisor = 24'($urandom_range(1, 40));
        end
        for (int i = 0; i < cfgN; i++) driveBit(b[i], d);
        sentPar = 1'b0;
        if (cfgPar) begin
            sentPar = (parForce < 0) ? refParity(b, cfgN, cfgMode) : (parForce != 0);
            driveBit(sentPar, d);
        end
        driveBit(s1, d);
        if (cfgTwo) driveBit(s2, d);
        rx = 1'b1;
        applyCfg();
    endtask

    task automatic expectFrame(input int k0, input logic [7:0] b, input logic sentPar,
                               input logic s1, input logic s2);
        recT        r;
        int         d;
        int         bits;
        logic [7:0] m;
        d     = effD();
        bits  = cfgN + (cfgPar ? 1 : 0) + 1 + (cfgTwo ? 1 : 0);
        m     = 8'((1 << cfgN) - 1);
        r.cyc = k0 + int'(SYNC) + d / 2 + bits * d + 1;
        r.d   = b & m;
        r.pe  = cfgPar && (sentPar != refParity(b, cfgN, cfgMode));
        r.fe  = !s1 || (cfgTwo && !s2);
`ifdef UART_RX_BREAK_DETECT_EN
        r.brk = (r.d == 8'h00) && (!cfgPar || !sentPar) && !s1;
`else
        r.brk = 1'b0;
`endif
        expQ.push_back(r);
    endtask

    task automatic compareAll(input string tag);
        int n;
        check($sformatf("%s.count", tag), 32'(got.size()), 32'(expQ.size()));
        n = (got.size() < expQ.size()) ? got.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d].cycle", tag, i), 32'(got[i].cyc), 32'(expQ[i].cyc));
            check($sformatf("%s[%0d].data", tag, i), 32'(got[i].d), 32'(expQ[i].d));
            check($sformatf("%s[%0d].parityError", tag, i), 32'(got[i].pe), 32'(expQ[i].pe));
            check($sformatf("%s[%0d].frameError", tag, i), 32'(got[i].fe), 32'(expQ[i].fe));
            check($sformatf("%s[%0d].breakDetected", tag, i), 32'(got[i].brk), 32'(expQ[i].brk));
        end
        got.delete();
        expQ.delete();
    endtask

    initial begin
        int         k0;
        int         k1;
        logic       sp;
        logic [7:0] b;
        int         pf;
        logic       s1;
        logic       s2;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.valid", 32'(bus.valid), 32'd0);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.data", 32'(bus.data), 32'd0);
        check("reset.parityError", 32'(bus.parityError), 32'd0);
        check("reset.frameError", 32'(bus.frameError), 32'd0);
`ifdef UART_RX_BREAK_DETECT_EN
        check("reset.breakDetected", 32'(bus.breakDetected), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);

        // 8N1, D=10, 0x60
        cfgN = 8; cfgPar = 0; cfgMode = 2'b00; cfgTwo = 0; cfgDiv = 10;
        sendFrame(8'h60, -1, 1'b1, 1'b1, 1'b0, k0, sp);
        expectFrame(k0, 8'h60, sp, 1'b1, 1'b1);
        idle(20);
        compareAll("8n1");

        // 7O1 0xA5, natural parity then forced wrong parity
        cfgN = 7; cfgPar = 1; cfgMode = 2'b10;
        sendFrame(8'hA5, -1, 1'b1, 1'b1, 1'b0, k0, sp);
        expectFrame(k0, 8'hA5, sp, 1'b1, 1'b1);
        idle(20);
        compareAll("7o1");
        sendFrame(8'hA5, 1, 1'b1, 1'b1, 1'b0, k0, sp);
        expectFrame(k0, 8'hA5, sp, 1'b1, 1'b1);
        idle(20);
        compareAll("7o1bad");

        // 8N2 with second stop low
        cfgN = 8; cfgPar = 0; cfgTwo = 1;
        sendFrame(8'h3C, -1, 1'b1, 1'b0, 1'b0, k0, sp);
        expectFrame(k0, 8'h3C, sp, 1'b1, 1'b0);
        idle(20);
        compareAll("8n2");

        // Same line with one stop bit: the low bit then reads as a new start
        // followed by an all-ones idle frame.
        cfgTwo = 0;
        sendFrame(8'h3C, -1, 1'b1, 1'b1, 1'b0, k0, sp);
        expectFrame(k0, 8'h3C, sp, 1'b1, 1'b1);
        k1 = cycle;
        driveBit(1'b0, 10);
        expectFrame(k1, 8'hFF, 1'b0, 1'b1, 1'b1);
        idle(120);
        compareAll("8n1line");

        // Glitch of 3 cycles
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        check("glitch.busyHigh", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        idle(20);
        @(negedge clk);
        check("glitch.busyLow", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        compareAll("glitch");

        // Reset during DATA of 0x55, then clean 0xAA
        applyCfg();
        driveBit(1'b0, 10);
        driveBit(1'b1, 10);
        driveBit(1'b0, 10);
        driveBit(1'b1, 10);
        @(negedge clk);
        check("rstmid.busyHigh", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(150);
        @(negedge clk);
        check("rstmid.busyLow", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        compareAll("rstmid");
        sendFrame(8'hAA, -1, 1'b1, 1'b1, 1'b0, k0, sp);
        expectFrame(k0, 8'hAA, sp, 1'b1, 1'b1);
        idle(20);
        compareAll("afterRst");

        // Break: line low for 20 bit times
        k0 = cycle;
        driveBit(1'b0, 200);
        expectFrame(k0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(5);
        sendFrame(8'hFF, -1, 1'b1, 1'b1, 1'b0, k1, sp);
`ifndef UART_RX_BREAK_DETECT_EN
        expectFrame(k1, 8'hFF, sp, 1'b1, 1'b1);
`endif
        idle(20);
        sendFrame(8'h5A, -1, 1'b1, 1'b1, 1'b0, k1, sp);
        expectFrame(k1, 8'h5A, sp, 1'b1, 1'b1);
        idle(20);
        compareAll("break");

        // Randomized frames, config scrambled mid-frame
        repeat (40) begin
            cfgN    = int'($urandom_range(5, 8));
            cfgPar  = 1'($urandom);
            cfgMode = 2'($urandom);
            cfgTwo  = 1'($urandom);
            cfgDiv  = int'($urandom_range(1, 14));
            b       = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            pf      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
            s1      = ($urandom_range(0, 4) != 0);
            s2      = ($urandom_range(0, 4) != 0);
            sendFrame(b, pf, s1, s2, 1'b1, k0, sp);
            expectFrame(k0, b, sp, s1, s2);
            idle(3 * effD());
            compareAll("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
